imem_port_arbiter: RTL
======================

// Module: imem_port_arbiter
// PURPOSE
// Shares the single-port instruction BRAM between three requesters: host write stream, fetch-stage reads and debug readback.
// Sits between the frontend control FSM and the BRAM, and owns all BRAM enable, address and write-data muxing.
// Tracks fixed BRAM read latency and returns tagged responses to the requester that issued each read.
// Guarantees debug forward progress with a starvation counter.
// PARAMETERS
// AW            10   BRAM address width
// DW            64   BRAM data width
// RD_LATENCY    2    BRAM read latency in cycles; valid range 1..4
// STARVE_LIMIT  8    consecutive lost debug cycles before debug wins one arbitration; valid range 1..255
// PORTS
// clk         in   1   single clock
// rst_n       in   1   asynchronous reset, active-low
// exec_active in   1   program executing (from frontend FSM)
// wr_valid    in   1   host write request
// wr_ready    out  1   host write accepted this cycle
// wr_addr     in   AW  host write address
// wr_data     in   DW  host write data
// fe_valid    in   1   fetch read request
// fe_ready    out  1   fetch read accepted this cycle
// fe_addr     in   AW  fetch read address
// fe_rvalid   out  1   fetch response valid
// fe_raddr    out  AW  address of the returned fetch word
// fe_rdata    out  DW  fetch response data
// dbg_valid   in   1   debug read request
// dbg_ready   out  1   debug read accepted this cycle
// dbg_addr    in   AW  debug read address
// dbg_rvalid  out  1   debug response valid
// dbg_rdata   out  DW  debug response data
// mem_en      out  1   BRAM enable
// mem_we      out  1   BRAM write enable
// mem_addr    out  AW  BRAM address
// mem_wdata   out  DW  BRAM write data; always equals wr_data
// mem_rdata   in   DW  BRAM read data
// BEHAVIOUR
// - Reset (rst_n=0, asynchronous): FSM goes to LOAD, starvation counter clears to 0, response pipeline clears.
//   All outputs are 0 except mem_wdata, which follows wr_data.
// - FSM state LOAD: entered from reset or DRAIN. Grants host writes and debug reads; fe_ready=0.
//   Moves to EXEC on the first cycle exec_active=1.
// - FSM state EXEC: grants fetch and debug reads; wr_ready=0. Moves to DRAIN when exec_active=0.
// - FSM state DRAIN: grants nothing. Moves to LOAD once the response pipeline is empty; 0 cycles in DRAIN if it is already empty.
// - Grants use the registered state only. exec_active never gates a grant combinationally.
// - Arbitration is combinational and at most one grant per cycle. Handshake is valid&ready.
// - Requesters hold valid/addr/data until ready; valid must not depend on ready.
// - Priority in LOAD is wr > dbg; priority in EXEC is fe > dbg.
// - Debug override: when starve_cnt==STARVE_LIMIT, dbg wins the cycle even if wr/fe is valid.
// - starve_cnt increments on any cycle with dbg_valid=1 and no dbg grant, except in DRAIN.
//   It clears on dbg grant or when dbg_valid=0, and saturates at STARVE_LIMIT.
// - On any grant, mem_en=1 in the same cycle. mem_we=1 only for a wr grant.
//   mem_addr is the granted requester's address, or 0 when there is no grant.
// - Read response: a read granted in cycle T returns its rvalid at cycle T+RD_LATENCY, exactly one cycle wide.
//   rdata is mem_rdata passed through in that cycle; fe_raddr is the address captured at grant.
// - The response tag/addr pipeline is RD_LATENCY deep, so back-to-back reads give back-to-back responses in grant order.
// - Writes produce no response. fe_rvalid and dbg_rvalid are never both 1.
// - fe_rdata/dbg_rdata are 0 when the matching rvalid=0.
// - Reads already in flight when exec_active falls are still returned, in DRAIN.
// - exec_active toggling while in DRAIN is ignored until LOAD is reached; from LOAD it re-enters EXEC the next cycle.
// - rst_n asserted mid-operation: in-flight responses are dropped and no rvalid follows reset.
// TESTING
// LOAD, wr_valid=1 for 4 cycles, addrs 0..3, data 0xA0..0xA3 -> mem_we=1 for 4 cycles, wr_ready=1 each, no rvalid.
// EXEC, fe_valid=1 for addrs 5,6,7, RD_LATENCY=2 -> fe_rvalid at T+2,T+3,T+4; fe_raddr 5,6,7; fe_rdata = BRAM words.
// EXEC, fe_valid and dbg_valid held high, STARVE_LIMIT=8 -> fe granted 8 cycles, dbg granted on 9th, counter back to 0.
// EXEC, fe read at T, then exec_active=0 at T+1 -> DRAIN; fe_rvalid at T+2; LOAD at T+3; wr_ready=0 before T+3.
// LOAD, wr_valid and dbg_valid together -> wr granted; dbg granted once the wr burst ends or the limit is reached.
// Two dbg reads in flight, rst_n pulsed low for 1 cycle -> no dbg_rvalid afterwards; FSM=LOAD; all outputs 0.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// Purpose : shares the single-port instruction BRAM between host writes, fetch reads and debug reads.
// Latency : grant and BRAM drive in the request cycle; a read response returns RD_LATENCY cycles later.
// Backpressure: ready is a same-cycle grant; the loser holds valid, and a starved debug read is forced through.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   exec_active                    program executing; steers LOAD/EXEC/DRAIN
//   wr_valid/ready/addr/data       host write stream (granted in LOAD)
//   fe_valid/ready/addr            fetch read requests (granted in EXEC)
//   fe_rvalid/raddr/rdata          tagged fetch responses
//   dbg_valid/ready/addr           debug read requests (granted in LOAD and EXEC)
//   dbg_rvalid/rdata               debug responses
//   mem_en/we/addr/wdata/rdata     BRAM port
module imem_port_arbiter #(
  parameter int AW           = 10,
  parameter int DW           = 64,
  parameter int RD_LATENCY   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          exec_active,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          fe_valid,
  output logic          fe_ready,
  input  logic [AW-1:0] fe_addr,
  output logic          fe_rvalid,
  output logic [AW-1:0] fe_raddr,
  output logic [DW-1:0] fe_rdata,
  input  logic          dbg_valid,
  output logic          dbg_ready,
  input  logic [AW-1:0] dbg_addr,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
  localparam int         LAST  = RD_LATENCY - 1;

  state_t                state_q, state_d;
  logic [7:0]            starve_cnt;
  logic [RD_LATENCY-1:0] pipe_vld;
  logic [RD_LATENCY-1:0] pipe_dbg;
  logic [AW-1:0]         pipe_addr [RD_LATENCY];

  logic gnt_wr, gnt_fe, gnt_dbg, rd_gnt, override, inflight_next;

  // Arbitration from the registered state only. Gating with rst_n keeps
  // every handshake and BRAM output low while reset is held.
  always_comb begin
    gnt_wr   = 1'b0;
    gnt_fe   = 1'b0;
    gnt_dbg  = 1'b0;
    override = (starve_cnt == LIMIT);
    if (rst_n) begin
      case (state_q)
        ST_LOAD: begin
          if (dbg_valid && override) gnt_dbg = 1'b1;
          else if (wr_valid)         gnt_wr  = 1'b1;
          else if (dbg_valid)        gnt_dbg = 1'b1;
        end
        ST_EXEC: begin
          if (dbg_valid && override) gnt_dbg = 1'b1;
          else if (fe_valid)         gnt_fe  = 1'b1;
          else if (dbg_valid)        gnt_dbg = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rd_gnt = gnt_fe | gnt_dbg;

  // Reads still owed a response after this edge: everything except the
  // one being returned this cycle, plus a read granted this cycle.
  always_comb begin
    inflight_next = rd_gnt;
    for (int i = 0; i < LAST; i++) begin
      inflight_next = inflight_next | pipe_vld[i];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD:  if (exec_active) state_d = ST_EXEC;
      ST_EXEC:  if (!exec_active) state_d = inflight_next ? ST_DRAIN : ST_LOAD;
      ST_DRAIN: if (!inflight_next) state_d = ST_LOAD;
      default:  state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Starvation counter: counts debug cycles lost to wr/fe. DRAIN grants
  // nobody, so a waiting debug read there is not counted as lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 8'd0;
    end else if (!dbg_valid || gnt_dbg) begin
      starve_cnt <= 8'd0;
    end else if (state_q != ST_DRAIN && starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  // Response tag pipeline, one stage per cycle of BRAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      pipe_dbg <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_addr[i] <= '0;
      end
    end else begin
      pipe_vld[0]  <= rd_gnt;
      pipe_dbg[0]  <= gnt_dbg;
      pipe_addr[0] <= gnt_dbg ? dbg_addr : fe_addr;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_dbg[i]  <= pipe_dbg[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
    end
  end

  assign wr_ready  = gnt_wr;
  assign fe_ready  = gnt_fe;
  assign dbg_ready = gnt_dbg;

  assign mem_en    = gnt_wr | rd_gnt;
  assign mem_we    = gnt_wr;
  assign mem_wdata = wr_data;
  assign mem_addr  = gnt_wr  ? wr_addr  :
                     gnt_fe  ? fe_addr  :
                     gnt_dbg ? dbg_addr : '0;

  assign fe_rvalid  = pipe_vld[LAST] & ~pipe_dbg[LAST];
  assign dbg_rvalid = pipe_vld[LAST] &  pipe_dbg[LAST];
  assign fe_raddr   = fe_rvalid  ? pipe_addr[LAST] : '0;
  assign fe_rdata   = fe_rvalid  ? mem_rdata : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

endmodule
